// File: rtl/lib_decmps_seq.sv
// Sequential one-hot decomposition: streams the set bits of an accepted vector as one-hot beats.
// Optional macro LIB_DECMPS_SEQ_ZERO_BEAT_EN: a zero vector emits a single all-zero last beat.
module lib_decmps_seq #(
    parameter int unsigned LSB_MSB = 0,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned IDX_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vect_vld,
    input  logic [WIDTH-1:0] vect,
    output logic             vect_rdy,
    output logic             onehot_vld,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] onehot_idx,
    output logic             onehot_last,
    input  logic             onehot_rdy,
    output logic             busy
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             out_q;
    logic             found;
    logic [IDX_W-1:0] ffs_idx;
    logic [WIDTH-1:0] ffs_sel;
    logic             transfer;
    logic             accept;
    logic             load;

    // Single find-first-set over the remainder; order fixed by LSB_MSB.
    always_comb begin
        found   = 1'b0;
        ffs_idx = '0;
        if (LSB_MSB == 0) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (!found && rem_q[i]) begin
                    found   = 1'b1;
                    ffs_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (!found && rem_q[i]) begin
                    found   = 1'b1;
                    ffs_idx = IDX_W'(i);
                end
            end
        end
        ffs_sel = found ? (WIDTH'(1) << ffs_idx) : '0;
    end

    always_comb begin
        onehot_vld  = (state_q == StRun);
        busy        = (state_q == StRun);
        onehot      = onehot_vld ? ffs_sel : '0;
        onehot_idx  = onehot_vld ? ffs_idx : '0;
        onehot_last = onehot_vld && ((rem_q & ~ffs_sel) == '0);
        transfer    = onehot_vld && onehot_rdy;
        // out_q holds vect_rdy low until the first edge after reset release.
        vect_rdy    = out_q && ((state_q == StIdle) || (transfer && onehot_last));
        accept      = vect_vld && vect_rdy;
`ifdef LIB_DECMPS_SEQ_ZERO_BEAT_EN
        load        = accept;
`else
        load        = accept && (vect != '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (transfer) begin
            rem_d = rem_q ^ ffs_sel;
            if (onehot_last) begin
                state_d = StIdle;
            end
        end
        if (load) begin
            rem_d   = vect;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            out_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lib_decmps_seq.sv
// Bench for lib_decmps_seq: LSB-first and MSB-first instances share stimulus; a queue model
// predicts the beat stream of each. Honours LIB_DECMPS_SEQ_ZERO_BEAT_EN.
module tb_lib_decmps_seq;

    localparam int unsigned W  = 8;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vect_vld = 1'b0;
    logic [W-1:0]  vect = '0;
    logic          onehot_rdy = 1'b0;

    logic          vrdy0, vld0, last0, busy0;
    logic [W-1:0]  oh0;
    logic [IW-1:0] idx0;
    logic          vrdy1, vld1, last1, busy1;
    logic [W-1:0]  oh1;
    logic [IW-1:0] idx1;

    int checks = 0;
    int errors = 0;
    int q0[$];
    int q1[$];
    bit out_en = 1'b0;

    always #5 clk = ~clk;

    lib_decmps_seq #(.LSB_MSB(0), .WIDTH(W)) dut0 (
        .clk(clk), .rst(rst), .vect_vld(vect_vld), .vect(vect), .vect_rdy(vrdy0),
        .onehot_vld(vld0), .onehot(oh0), .onehot_idx(idx0), .onehot_last(last0),
        .onehot_rdy(onehot_rdy), .busy(busy0)
    );

    lib_decmps_seq #(.LSB_MSB(1), .WIDTH(W)) dut1 (
        .clk(clk), .rst(rst), .vect_vld(vect_vld), .vect(vect), .vect_rdy(vrdy1),
        .onehot_vld(vld1), .onehot(oh1), .onehot_idx(idx1), .onehot_last(last1),
        .onehot_rdy(onehot_rdy), .busy(busy1)
    );

    function automatic void chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endfunction

    function automatic logic [W-1:0] bit_of(input int p);
        logic [W-1:0] one;
        one = 1;
        return (p < 0) ? '0 : (one << p);
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, ".vld0"}, 32'(vld0), 0);   chk({tag, ".vld1"}, 32'(vld1), 0);
        chk({tag, ".oh0"}, 32'(oh0), 0);     chk({tag, ".oh1"}, 32'(oh1), 0);
        chk({tag, ".idx0"}, 32'(idx0), 0);   chk({tag, ".last0"}, 32'(last0), 0);
        chk({tag, ".busy0"}, 32'(busy0), 0); chk({tag, ".busy1"}, 32'(busy1), 0);
        chk({tag, ".rdy0"}, 32'(vrdy0), 0);  chk({tag, ".rdy1"}, 32'(vrdy1), 0);
    endtask

    // One cycle: drive, check at negedge against the model, then advance the model.
    task automatic step(input logic vv, input logic [W-1:0] v, input logic rdy);
        bit exp_rdy;
        vect_vld   = vv;
        vect       = v;
        onehot_rdy = rdy;
        @(negedge clk);
        exp_rdy = out_en && (q0.size() == 0 || (rdy && q0.size() == 1));
        chk("vect_rdy0", 32'(vrdy0), 32'(exp_rdy));
        chk("vect_rdy1", 32'(vrdy1), 32'(exp_rdy));
        chk("vld0", 32'(vld0), 32'(q0.size() != 0));
        chk("vld1", 32'(vld1), 32'(q1.size() != 0));
        chk("busy0", 32'(busy0), 32'(q0.size() != 0));
        if (q0.size() != 0) begin
            chk("onehot0", 32'(oh0), 32'(bit_of(q0[0])));
            chk("idx0", 32'(idx0), (q0[0] < 0) ? 0 : q0[0]);
            chk("last0", 32'(last0), 32'(q0.size() == 1));
        end
        if (q1.size() != 0) begin
            chk("onehot1", 32'(oh1), 32'(bit_of(q1[0])));
            chk("idx1", 32'(idx1), (q1[0] < 0) ? 0 : q1[0]);
            chk("last1", 32'(last1), 32'(q1.size() == 1));
        end
        if (rdy && q0.size() != 0) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (vv && exp_rdy) begin
            for (int i = 0; i < int'(W); i++) if (v[i]) q0.push_back(i);
            for (int i = int'(W) - 1; i >= 0; i--) if (v[i]) q1.push_back(i);
`ifdef LIB_DECMPS_SEQ_ZERO_BEAT_EN
            if (v == '0) begin
                q0.push_back(-1);
                q1.push_back(-1);
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, and vect_rdy stays low until an edge after release.
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rdy_before_edge", 32'(vrdy0), 0);
        @(posedge clk);
        #1 out_en = 1'b1;

        // Four beats in each search order.
        step(1'b1, 8'b1010_0110, 1'b1);
        repeat (5) step(1'b0, 8'hff, 1'b1);

        // Backpressure holds the head beat.
        step(1'b1, 8'h11, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Back-to-back: new vector on the last-beat cycle.
        step(1'b1, 8'h03, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h80, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b1);

        // Zero vector.
        step(1'b1, 8'h00, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b1);

        // Reset mid-run discards the remainder.
        step(1'b1, 8'hff, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        #1;
        check_idle_zero("midrun_rst");
        q0.delete();
        q1.delete();
        out_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 out_en = 1'b1;
        repeat (4) step(1'b0, 8'h00, 1'b1);

        // Randomized traffic with random backpressure and ignored non-ready vectors.
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] rv;
            rv = W'($urandom);
            if ($urandom_range(0, 7) == 0) rv = '0;
            step(1'($urandom_range(0, 2) == 0), rv, 1'($urandom_range(0, 3) != 0));
        end
        repeat (12) step(1'b0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
